regwr_port_arbiter: RTL and testbench
=====================================

# regwr_port_arbiter

Shares the register file's single write port between the pipeline writeback path and a host/accelerator write channel, such as FFT result or frequency-table loads. Pipeline writeback has priority. Host writes are buffered in a small FIFO. A starvation counter forces a one-cycle pipeline stall so that queued host writes always drain. The block sits between writeback, the host channel, and the register file write inputs (write enable, write register, write data).

## Interface
Parameters:
- DATAW, 32, register data width
- REGW, 3, register index width
- FIFO_DEPTH, 2, host FIFO entries; allowed values 2..8
- STARVE_LIMIT, 4, consecutive denied cycles before a forced host grant; minimum 1

Ports:
- clk, input, 1, single clock; all state on the rising edge
- rst_n, input, 1, synchronous, active-low reset
- wb_en, input, 1, pipeline writeback request
- wb_reg, input, REGW, writeback destination
- wb_data, input, DATAW, writeback data
- host_valid, input, 1, host write request
- host_ready, output, 1, FIFO can accept a host write
- host_reg, input, REGW, host destination
- host_data, input, DATAW, host data
- stall, output, 1, registered; pipeline must freeze and hold its writeback stable
- wr_reg_en, output, 1, register file write enable
- wr_reg, output, REGW, register file write index
- wr_data, output, DATAW, register file write data
- host_grant, output, 1, the FIFO head is written this cycle

## Operation
- **Host accept:** a host write is accepted when host_valid && host_ready.
  - host_ready = !rst_n ? 0 : (count < FIFO_DEPTH), computed from the current count only.
  - A full FIFO does not accept a push in the same cycle as a pop.
- **Write-port selection (combinational, from current state and inputs):**
  - stall=1 and FIFO nonempty: host_grant=1. The FIFO head drives wr_reg/wr_data. wb_en is ignored this cycle; the pipeline re-presents it next cycle.
  - else wb_en=1: wb_reg/wb_data drive the port, host_grant=0.
  - else FIFO nonempty: host_grant=1, the head drives the port.
  - else wr_reg_en=0, and wr_reg/wr_data are 0.
  - wr_reg_en = host_grant | (wb_en & !stall).
- **FIFO:** a circular buffer with a head pointer, a tail pointer and a count of width $clog2(FIFO_DEPTH+1).
  - Pop on host_grant.
  - Push and pop in the same cycle keeps the count unchanged.
  - Pointers wrap at FIFO_DEPTH.
- **Starvation counter (scnt):**
  - A denied cycle is one where the FIFO is nonempty, wb_en=1 and host_grant=0. scnt increments on each denied cycle.
  - scnt clears to 0 on host_grant or when the FIFO is empty.
  - On a denied cycle with scnt==STARVE_LIMIT-1: next cycle stall=1 and scnt=0.
- **Stall:**
  - stall lasts exactly one cycle; it is never asserted two cycles in a row.
  - stall is never asserted while the FIFO is empty.
  - If the FIFO empties before the stall cycle, stall=1 still occurs but grants nothing. This cannot happen with pops only on grant; it is listed for completeness.
- **Ordering:**
  - Host writes retire in acceptance order.
  - Writes to the same register from both sources take effect in grant order. No merging or forwarding is done.

## Timing
- Reset (rst_n=0 at a rising edge): FIFO empty, scnt=0, stall=0.
  - While rst_n=0: host_ready=0, host_grant=0.
  - While rst_n=0, wr_reg_en follows wb_en. The pipeline is also in reset, so wb_en=0.
  - Reset mid-operation discards all queued host writes.
- Host latency: a write accepted at edge t is written at the earliest in the cycle after t. There is no FIFO bypass.
- Host throughput: 1 write per cycle while wb_en=0.
- Worst-case host wait with continuous wb_en: STARVE_LIMIT denied cycles plus 1 stall cycle.
- The write port is combinational from the state; the register file captures it at the next edge.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles with host_valid=1 -> host_ready=0, stall=0, wr_reg_en=0, and no FIFO push.
- **Idle host burst:** wb_en=0; push (r1,0xA), (r2,0xB), (r3,0xC) back-to-back.
  - The three writes appear on the port in order, on the cycles after each acceptance.
  - host_ready stays 1 with FIFO_DEPTH=2.
- **Priority:** wb_en=1 (r4,0x11) in the same cycle the FIFO holds (r5,0x22) -> port writes r4 first; r5 is written on the first cycle with wb_en=0.
- **Starvation:** STARVE_LIMIT=4, continuous wb_en=1, one host entry queued.
  - 4 denied cycles, then stall=1 for one cycle with host_grant=1, then scnt=0.
  - The held writeback is written the cycle after the stall.
- **Full FIFO:** fill 2 entries with wb_en=1 held -> host_ready=0. A simultaneous pop and push attempt is refused. host_ready returns to 1 the cycle after the pop.
- **Wrap-around:** push and pop 2*FIFO_DEPTH+1 entries with distinct data -> all are written in order with no loss or duplication.

Source files
------------

// File: rtl/regwr_port_arbiter_if.sv
// Bundle of the writeback, host write channel and register-file write port
// signals shared between the pipeline/host side and the write-port arbiter.
interface regwr_port_arbiter_if #(
  parameter int DATAW = 32,
  parameter int REGW  = 3
);
  logic             wb_en;
  logic [REGW-1:0]  wb_reg;
  logic [DATAW-1:0] wb_data;
  logic             host_valid;
  logic             host_ready;
  logic [REGW-1:0]  host_reg;
  logic [DATAW-1:0] host_data;
  logic             stall;
  logic             wr_reg_en;
  logic [REGW-1:0]  wr_reg;
  logic [DATAW-1:0] wr_data;
  logic             host_grant;

  // Requesters: pipeline writeback and host channel, observing the port.
  modport master (
    output wb_en, wb_reg, wb_data, host_valid, host_reg, host_data,
    input  host_ready, stall, wr_reg_en, wr_reg, wr_data, host_grant
  );

  // The arbiter itself.
  modport slave (
    input  wb_en, wb_reg, wb_data, host_valid, host_reg, host_data,
    output host_ready, stall, wr_reg_en, wr_reg, wr_data, host_grant
  );
endinterface

// File: rtl/regwr_port_arbiter.sv
// Register-file write-port arbiter. Writeback wins by default; host writes
// queue in a small circular FIFO and a starvation counter forces a one-cycle
// pipeline stall so that queued host writes always drain.
module regwr_port_arbiter #(
  parameter int DATAW        = 32,
  parameter int REGW         = 3,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regwr_port_arbiter_if.slave  bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

  // The head entry drives the port in the same cycle it is granted, so the
  // storage is read asynchronously (a few flops, not a block RAM).
  logic [REGW-1:0]  reg_mem  [FIFO_DEPTH];
  logic [DATAW-1:0] data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] entry_we;

  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic [SW-1:0] scnt_reg, scnt_next;
  logic          stall_reg, stall_next;

  logic fifo_nonempty;
  logic stall_eff;
  logic push;
  logic pop;
  logic denied;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_nonempty  = (count_reg != '0);
  // A stale stall must not suppress writeback while in reset.
  assign stall_eff      = stall_reg & rst_n;
  assign bus.host_ready = rst_n & (count_reg < CW'(FIFO_DEPTH));
  assign bus.host_grant = rst_n & fifo_nonempty & (stall_eff | ~bus.wb_en);
  assign bus.wr_reg_en  = bus.host_grant | (bus.wb_en & ~stall_eff);
  assign bus.stall      = stall_reg;
  assign push           = bus.host_valid & bus.host_ready;
  assign pop            = bus.host_grant;
  assign denied         = fifo_nonempty & bus.wb_en & ~bus.host_grant;

  // Per-entry write enable: only the slot under the tail pointer takes a push.
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : gen_we
      assign entry_we[gi] = push & (tail_reg == PW'(gi));
    end
  endgenerate

  // FIFO payload storage; contents need no reset since count gates them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_we[i]) begin
        reg_mem[i]  <= bus.host_reg;
        data_mem[i] <= bus.host_data;
      end
    end
  end

  // Write-port mux: granted host head, else writeback, else idle zeros.
  always_comb begin
    bus.wr_reg  = '0;
    bus.wr_data = '0;
    if (bus.host_grant) begin
      bus.wr_reg  = reg_mem[head_reg];
      bus.wr_data = data_mem[head_reg];
    end else if (bus.wb_en) begin
      bus.wr_reg  = bus.wb_reg;
      bus.wr_data = bus.wb_data;
    end
  end

  // Next-state for pointers, occupancy, starvation counter and stall.
  always_comb begin
    head_next  = pop  ? ptr_inc(head_reg) : head_reg;
    tail_next  = push ? ptr_inc(tail_reg) : tail_reg;
    count_next = CW'(count_reg + CW'(push) - CW'(pop));
    stall_next = 1'b0;
    scnt_next  = scnt_reg;
    if (bus.host_grant || !fifo_nonempty) begin
      scnt_next = '0;
    end else if (denied) begin
      if (scnt_reg == SW'(STARVE_LIMIT - 1)) begin
        scnt_next  = '0;
        stall_next = 1'b1;
      end else begin
        scnt_next = scnt_reg + 1'b1;
      end
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      scnt_reg  <= '0;
      stall_reg <= 1'b0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      scnt_reg  <= scnt_next;
      stall_reg <= stall_next;
    end
  end

endmodule

// File: tb/tb_regwr_port_arbiter.sv
// Directed, table-driven bench for regwr_port_arbiter (DEPTH=2, LIMIT=4).
module tb_regwr_port_arbiter;

  logic clk;
  logic rst_n;

  regwr_port_arbiter_if #(.DATAW(32), .REGW(3)) bus ();

  regwr_port_arbiter #(
    .DATAW(32), .REGW(3), .FIFO_DEPTH(2), .STARVE_LIMIT(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        wb_en;
    logic [2:0]  wb_reg;
    logic [31:0] wb_data;
    logic        host_valid;
    logic [2:0]  host_reg;
    logic [31:0] host_data;
    logic        e_ready;
    logic        e_stall;
    logic        e_en;
    logic [2:0]  e_reg;
    logic [31:0] e_data;
    logic        e_grant;
  } vec_t;

  vec_t tbl[$];
  int tests = 0;
  int fails = 0;

  function automatic vec_t mk(
    input logic r, input logic we, input logic [2:0] wr, input logic [31:0] wd,
    input logic hv, input logic [2:0] hr, input logic [31:0] hd,
    input logic ry, input logic st, input logic en, input logic [2:0] rg,
    input logic [31:0] dt, input logic gr);
    vec_t v;
    v.rst_n = r; v.wb_en = we; v.wb_reg = wr; v.wb_data = wd;
    v.host_valid = hv; v.host_reg = hr; v.host_data = hd;
    v.e_ready = ry; v.e_stall = st; v.e_en = en; v.e_reg = rg;
    v.e_data = dt; v.e_grant = gr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive just after the rising edge, check on the falling edge.
  task automatic run_vec(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    rst_n          = v.rst_n;
    bus.wb_en      = v.wb_en;
    bus.wb_reg     = v.wb_reg;
    bus.wb_data    = v.wb_data;
    bus.host_valid = v.host_valid;
    bus.host_reg   = v.host_reg;
    bus.host_data  = v.host_data;
    @(negedge clk);
    chk({tag, ".host_ready"}, 32'(bus.host_ready), 32'(v.e_ready));
    chk({tag, ".stall"},      32'(bus.stall),      32'(v.e_stall));
    chk({tag, ".wr_reg_en"},  32'(bus.wr_reg_en),  32'(v.e_en));
    chk({tag, ".wr_reg"},     32'(bus.wr_reg),     32'(v.e_reg));
    chk({tag, ".wr_data"},    bus.wr_data,         v.e_data);
    chk({tag, ".host_grant"}, 32'(bus.host_grant), 32'(v.e_grant));
    $display("[TB] %s rst_n=%0b wb_en=%0b hv=%0b -> rdy=%0b stall=%0b en=%0b reg=%0d data=%0h grant=%0b",
             tag, v.rst_n, v.wb_en, v.host_valid, bus.host_ready, bus.stall,
             bus.wr_reg_en, bus.wr_reg, bus.wr_data, bus.host_grant);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.wb_en = 1'b0; bus.wb_reg = '0; bus.wb_data = '0;
    bus.host_valid = 1'b0; bus.host_reg = '0; bus.host_data = '0;

    //                  rst we wr  wdata     hv hr  hdata    | rdy st en rg  data      gr
    // reset with host_valid held: nothing accepted
    tbl.push_back(mk(0, 0, 0, 32'h0,  1, 7, 32'h99, 0, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(0, 0, 0, 32'h0,  1, 7, 32'h99, 0, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(0, 0, 0, 32'h0,  1, 7, 32'h99, 0, 0, 0, 0, 32'h0,  0));
    // idle host burst: each write appears the cycle after acceptance
    tbl.push_back(mk(1, 0, 0, 32'h0,  1, 1, 32'hA,  1, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 0, 0, 32'h0,  1, 2, 32'hB,  1, 0, 1, 1, 32'hA,  1));
    tbl.push_back(mk(1, 0, 0, 32'h0,  1, 3, 32'hC,  1, 0, 1, 2, 32'hB,  1));
    tbl.push_back(mk(1, 0, 0, 32'h0,  0, 0, 32'h0,  1, 0, 1, 3, 32'hC,  1));
    tbl.push_back(mk(1, 0, 0, 32'h0,  0, 0, 32'h0,  1, 0, 0, 0, 32'h0,  0));
    // priority: writeback beats a queued host entry
    tbl.push_back(mk(1, 0, 0, 32'h0,  1, 5, 32'h22, 1, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 1, 4, 32'h11, 0, 0, 32'h0,  1, 0, 1, 4, 32'h11, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,  0, 0, 32'h0,  1, 0, 1, 5, 32'h22, 1));
    // full FIFO: refused push while full, even with a simultaneous pop
    tbl.push_back(mk(1, 1, 6, 32'h33, 1, 1, 32'h44, 1, 0, 1, 6, 32'h33, 0));
    tbl.push_back(mk(1, 1, 6, 32'h33, 1, 2, 32'h55, 1, 0, 1, 6, 32'h33, 0));
    tbl.push_back(mk(1, 1, 6, 32'h33, 1, 3, 32'h66, 0, 0, 1, 6, 32'h33, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,  1, 3, 32'h66, 0, 0, 1, 1, 32'h44, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,  1, 3, 32'h66, 1, 0, 1, 2, 32'h55, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,  0, 0, 32'h0,  1, 0, 1, 3, 32'h66, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,  0, 0, 32'h0,  1, 0, 0, 0, 32'h0,  0));
    // reset mid-operation discards the queued entry; wr_reg_en follows wb_en
    tbl.push_back(mk(1, 0, 0, 32'h0,  1, 4, 32'h77, 1, 0, 0, 0, 32'h0,  0));
    tbl.push_back(mk(0, 1, 1, 32'h12, 1, 5, 32'h88, 0, 0, 1, 1, 32'h12, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,  0, 0, 32'h0,  1, 0, 0, 0, 32'h0,  0));

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Starvation: one queued entry, continuous writeback.
    // 4 denied cycles, one stall cycle granting the host, then writeback.
    run_vec(mk(1, 1, 4, 32'hCD, 1, 7, 32'hAB, 1, 0, 1, 4, 32'hCD, 0), "starve_push");
    for (int k = 0; k < 4; k++)
      run_vec(mk(1, 1, 4, 32'hCD, 0, 0, 32'h0, 1, 0, 1, 4, 32'hCD, 0),
              $sformatf("starve_deny%0d", k));
    run_vec(mk(1, 1, 4, 32'hCD, 0, 0, 32'h0, 1, 1, 1, 7, 32'hAB, 1), "starve_stall");
    run_vec(mk(1, 1, 4, 32'hCD, 0, 0, 32'h0, 1, 0, 1, 4, 32'hCD, 0), "starve_after");
    run_vec(mk(1, 0, 0, 32'h0,  0, 0, 32'h0, 1, 0, 0, 0, 32'h0,  0), "starve_idle");

    // Wrap-around: 2*DEPTH+1 back-to-back pushes, each written one cycle later.
    begin
      logic [34:0] exp_q[$];
      logic [34:0] head;
      for (int i = 0; i <= 5; i++) begin
        vec_t v;
        v = mk(1, 0, 0, 32'h0, (i < 5), 3'(i + 1), 32'h100 + 32'(i),
               1, 0, 0, 0, 32'h0, 0);
        if (exp_q.size() > 0) begin
          head = exp_q.pop_front();
          v.e_en = 1'b1; v.e_grant = 1'b1;
          v.e_reg = head[34:32]; v.e_data = head[31:0];
        end
        if (i < 5) exp_q.push_back({3'(i + 1), 32'h100 + 32'(i)});
        run_vec(v, $sformatf("wrap%0d", i));
      end
      chk("wrap.drained", 32'(exp_q.size()), 32'd0);
      run_vec(mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 0), "wrap_idle");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
